// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD serial subtractor.
//   BCD_DIGIT_W    : bits per BCD digit
//   BCD_RADIX      : decimal radix used to correct negative digit differences
//   bcd_digit_t    : one packed BCD digit
//   bcd_sub_state_e: control states of the serial subtractor
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_RADIX   = 10;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  // NEG is only reachable when BCD_SUB_MAGNITUDE_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } bcd_sub_state_e;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor (combinational).
//   a_d  : minuend digit
//   b_d  : subtrahend digit
//   bin  : borrow-in
//   d    : result digit (ten's-complement corrected)
//   bout : borrow-out, set when a_d - b_d - bin is negative
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout
);

  // One extra bit holds the sign: a_d - b_d - bin spans -16..15.
  logic [BCD_DIGIT_W:0] t;

  always_comb begin
    t    = {1'b0, a_d} - {1'b0, b_d} - {{BCD_DIGIT_W{1'b0}}, bin};
    bout = t[BCD_DIGIT_W];
    d    = bout ? (t[BCD_DIGIT_W-1:0] + bcd_digit_t'(BCD_RADIX)) : t[BCD_DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock, LSD first.
// Operands enter on an in_valid/in_ready handshake; the result is held on
// out_valid/out_ready until taken.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (accepted only in IDLE)
//   a, b, bin           : minuend, subtrahend (packed BCD), borrow-in
//   out_valid, out_ready: result handshake
//   diff, bout          : result (packed BCD) and final borrow (1 = negative result)
//   err                 : some operand digit was > 9; diff/bout are then forced to 0
//   neg                 : magnitude sign, only driven when BCD_SUB_MAGNITUDE_EN is defined
// Optional feature macro: BCD_SUB_MAGNITUDE_EN -- negative results are converted to
// their magnitude by a second serial pass (0 - diff) and flagged with neg.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] b,
  input  logic                           bin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] diff,
  output logic                           bout,
  output logic                           err,
  output logic                           neg
);

  localparam int unsigned W    = BCD_DIGIT_W * NUM_DIGITS;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  bcd_sub_state_e state_q, state_d;

  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    diff_q, diff_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            borrow_q, borrow_d;
  logic            bout_q, bout_d;
  logic            err_q, err_d;
  logic            neg_q, neg_d;

  bcd_digit_t      dig_d;
  logic            dig_bout;
  logic            last_digit;
  logic            in_err;
  logic [W-1:0]    diff_shift;

  // One digit cell serves both passes: NEG loads a_q with zero and b_q with the
  // first-pass result, so the operand LSDs are always the cell inputs.
  bcd_digit_sub u_digit_sub (
    .a_d  (bcd_digit_t'(a_q[BCD_DIGIT_W-1:0])),
    .b_d  (bcd_digit_t'(b_q[BCD_DIGIT_W-1:0])),
    .bin  (borrow_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  assign last_digit = (idx_q == IdxW'(NUM_DIGITS - 1));
  // New digit enters at the MSD end; after NUM_DIGITS shifts the LSD sits at the bottom.
  assign diff_shift = W'({dig_d, diff_q} >> BCD_DIGIT_W);

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      in_err = in_err
             | (a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > bcd_digit_t'(BCD_RADIX - 1))
             | (b[i*BCD_DIGIT_W +: BCD_DIGIT_W] > bcd_digit_t'(BCD_RADIX - 1));
    end
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      err_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      err_q    <= err_d;
      neg_q    <= neg_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN: begin
        if (last_digit) begin
          state_d = DONE;
`ifdef BCD_SUB_MAGNITUDE_EN
          if (dig_bout && !err_q) state_d = NEG;
`endif
        end
      end
`ifdef BCD_SUB_MAGNITUDE_EN
      NEG:  if (last_digit) state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    err_d    = err_q;
    neg_d    = neg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
          diff_d   = '0;
          bout_d   = 1'b0;
          err_d    = in_err;
          neg_d    = 1'b0;
        end
      end
      RUN: begin
        a_d      = a_q >> BCD_DIGIT_W;
        b_d      = b_q >> BCD_DIGIT_W;
        borrow_d = dig_bout;
        idx_d    = idx_q + IdxW'(1);
        diff_d   = diff_shift;
        if (last_digit) begin
          idx_d = '0;
          if (err_q) begin
            diff_d = '0;
            bout_d = 1'b0;
          end else begin
            bout_d = dig_bout;
`ifdef BCD_SUB_MAGNITUDE_EN
            if (dig_bout) begin
              // Second pass computes 0 - diff with no borrow-in.
              a_d      = '0;
              b_d      = diff_shift;
              borrow_d = 1'b0;
            end
`endif
          end
        end
      end
`ifdef BCD_SUB_MAGNITUDE_EN
      NEG: begin
        a_d      = a_q >> BCD_DIGIT_W;
        b_d      = b_q >> BCD_DIGIT_W;
        borrow_d = dig_bout;
        idx_d    = idx_q + IdxW'(1);
        diff_d   = diff_shift;
        if (last_digit) begin
          idx_d = '0;
          neg_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    diff      = diff_q;
    bout      = bout_q;
    err       = err_q;
`ifdef BCD_SUB_MAGNITUDE_EN
    neg       = neg_q;
`else
    neg       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor: directed cases plus randomized
// operands checked against a decimal-arithmetic reference model.
module tb_bcd_serial_subtractor;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         err;
  logic         neg;

  int n_checks = 0;
  int n_errors = 0;

  bcd_serial_subtractor #(.NUM_DIGITS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .err       (err),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint bcd_to_int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = int'(N) - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input longint v);
    logic [W-1:0] r = '0;
    longint       t = v;
    for (int i = 0; i < int'(N); i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal arithmetic on the operand values.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] ediff, output logic ebout, output logic eerr,
                       output logic eneg, output int elat);
    longint modv = 1;
    longint r;
    eerr = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      modv = modv * 10;
      if (ma[i*4 +: 4] > 4'd9 || mb[i*4 +: 4] > 4'd9) eerr = 1'b1;
    end
    ediff = '0;
    ebout = 1'b0;
    eneg  = 1'b0;
    elat  = int'(N);
    if (!eerr) begin
      r = bcd_to_int(ma) - bcd_to_int(mb) - longint'(mbin);
      if (r < 0) begin
        ebout = 1'b1;
`ifdef BCD_SUB_MAGNITUDE_EN
        ediff = int_to_bcd((-r) % modv);
        eneg  = 1'b1;
        elat  = 2 * int'(N);
`else
        ediff = int_to_bcd(r + modv);
`endif
      end else begin
        ediff = int_to_bcd(r);
      end
    end
  endtask

  // Issue one operation from IDLE, check latency, result, hold behaviour and release.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbin,
                        input int hold);
    logic [W-1:0] ediff;
    logic         ebout, eerr, eneg;
    int           elat;
    int           cycles;
    model(ta, tbv, tbin, ediff, ebout, eerr, eneg, elat);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tbv; bin = tbin; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    cycles = 0;
    while (!out_valid && cycles < 4 * int'(N) + 4) begin
      check_eq("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      cycles++;
    end
    check_eq("latency", 32'(cycles), 32'(elat));
    check_eq("out_valid", 32'(out_valid), 32'd1);
    check_eq("diff", 32'(diff), 32'(ediff));
    check_eq("bout", 32'(bout), 32'(ebout));
    check_eq("err", 32'(err), 32'(eerr));
    check_eq("neg", 32'(neg), 32'(eneg));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_ready", 32'(in_ready), 32'd0);
      check_eq("hold_diff", 32'(diff), 32'(ediff));
      check_eq("hold_bout", 32'(bout), 32'(ebout));
      check_eq("hold_err", 32'(err), 32'(eerr));
      check_eq("hold_neg", 32'(neg), 32'(eneg));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("release_valid", 32'(out_valid), 32'd0);
    check_eq("release_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < int'(N); i++) r[i*4 +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    int           k;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_diff", 32'(diff), 32'd0);
    check_eq("rst_flags", {29'd0, bout, err, neg}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h4321, 16'h1234, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 1);
    run_op(16'h1000, 16'h0999, 1'b1, 0);
    run_op(16'h12A4, 16'h0001, 1'b0, 0);
    run_op(16'h0000, 16'h9999, 1'b1, 0);
    run_op(16'h9999, 16'h9999, 1'b0, 0);
    // Long hold, then back-to-back second operand.
    run_op(16'h5678, 16'h1234, 1'b1, 5);
    run_op(16'h0042, 16'h0043, 1'b0, 0);

    // Reset while RUN is on digit 2.
    a = 16'h9876; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_diff", 32'(diff), 32'd0);
    check_eq("midrst_flags", {29'd0, bout, err, neg}, 32'd0);
    for (int i = 0; i < 2 * int'(N) + 2; i++) begin
      @(posedge clk); #1;
      check_eq("midrst_no_out", 32'(out_valid), 32'd0);
    end
    run_op(16'h2500, 16'h0499, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(7, 0) == 0) begin
        k = int'($urandom_range(N - 1, 0));
        if ($urandom_range(1, 0) == 1) ra[k*4 +: 4] = 4'($urandom_range(15, 10));
        else rb[k*4 +: 4] = 4'($urandom_range(15, 10));
      end
      run_op(ra, rb, 1'($urandom), int'($urandom_range(3, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
